antirrebote_scheduler: RTL and testbench

Multi-channel switch debounce controller. It shares one prescaler tick across N_CH per-channel debounce FSMs (Cero / Espera_a_1 / Uno / Espera_a_0). Debounced level changes are queued as per-channel pending events. A round-robin arbiter serialises those events onto one valid/ready event port, which feeds the downstream control logic that consumes button/switch presses.

---
 rtl/antirrebote_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_antirrebote_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/antirrebote_scheduler.sv
// Multi-channel switch debouncer: shared prescaler tick, per-channel debounce FSMs,
// pending-event latches and a round-robin arbiter onto a single valid/ready event port.
module antirrebote_scheduler #(
    parameter int N_CH         = 4,
    parameter int CH_W         = 2,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_db,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_level,
    output logic [N_CH-1:0] evt_ovf,
    input  logic            ovf_clr
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(STABLE_TICKS - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        CERO       = 2'd0,
        ESPERA_A_1 = 2'd1,
        UNO        = 2'd2,
        ESPERA_A_0 = 2'd3
    } db_state_t;

    logic [N_CH-1:0] sync_ff1;
    logic [N_CH-1:0] sw_s;
    logic [PW-1:0]   presc;
    logic            tick;

    db_state_t       state     [N_CH];
    db_state_t       state_nxt [N_CH];
    logic [CW-1:0]   cnt       [N_CH];
    logic [CW-1:0]   cnt_nxt   [N_CH];
    logic [N_CH-1:0] commit;
    logic [N_CH-1:0] commit_lvl;

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pend_lvl;
    logic [CH_W-1:0] ptr;
    logic            out_free;
    logic            grant_any;
    logic [CH_W-1:0] grant_ch;
    logic [N_CH-1:0] granted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff1 <= '0;
            sw_s     <= '0;
        end else begin
            sync_ff1 <= sw_in;
            sw_s     <= sync_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    presc <= '0;
        else if (presc == PRESC_LAST) presc <= '0;
        else                          presc <= presc + 1'b1;
    end

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= CERO;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                CERO: if (sw_s[i]) begin
                    state_nxt[i] = ESPERA_A_1;
                    cnt_nxt[i]   = '0;
                end
                ESPERA_A_1: begin
                    if (!sw_s[i])                   state_nxt[i] = CERO;
                    else if (tick && cnt[i] == CNT_LAST) state_nxt[i] = UNO;
                    else if (tick)                  cnt_nxt[i]   = cnt[i] + 1'b1;
                end
                UNO: if (!sw_s[i]) begin
                    state_nxt[i] = ESPERA_A_0;
                    cnt_nxt[i]   = '0;
                end
                ESPERA_A_0: begin
                    if (sw_s[i])                    state_nxt[i] = UNO;
                    else if (tick && cnt[i] == CNT_LAST) state_nxt[i] = CERO;
                    else if (tick)                  cnt_nxt[i]   = cnt[i] + 1'b1;
                end
                default: state_nxt[i] = CERO;
            endcase
        end
    end

    always_comb begin
        commit     = '0;
        commit_lvl = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (state[i] == ESPERA_A_1 && sw_s[i] && tick && cnt[i] == CNT_LAST) begin
                commit[i]     = 1'b1;
                commit_lvl[i] = 1'b1;
            end
            if (state[i] == ESPERA_A_0 && !sw_s[i] && tick && cnt[i] == CNT_LAST) begin
                commit[i]     = 1'b1;
                commit_lvl[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_db <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (commit[i]) sw_db[i] <= commit_lvl[i];
        end
    end

    // Scan downwards so the pending channel closest to the pointer is the one left in grant_ch.
    always_comb begin
        logic [CH_W:0]   sum;
        logic [CH_W-1:0] idx;
        out_free  = !evt_valid || evt_ready;
        grant_any = 1'b0;
        grant_ch  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (CH_W + 1)'(k);
            if (sum >= (CH_W + 1)'(N_CH)) sum = sum - (CH_W + 1)'(N_CH);
            idx = sum[CH_W-1:0];
            if (pend[idx]) begin
                grant_any = 1'b1;
                grant_ch  = idx;
            end
        end
        granted = '0;
        if (out_free && grant_any) granted[grant_ch] = 1'b1;
    end

    // A fresh commit outranks the clear from a grant in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            pend_lvl <= '0;
            evt_ovf  <= '0;
        end else begin
            if (ovf_clr) evt_ovf <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (granted[i]) pend[i] <= 1'b0;
                if (commit[i]) begin
                    pend[i]     <= 1'b1;
                    pend_lvl[i] <= commit_lvl[i];
                    if (pend[i] && !granted[i]) evt_ovf[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_level <= 1'b0;
            ptr       <= '0;
        end else if (out_free) begin
            if (grant_any) begin
                evt_valid <= 1'b1;
                evt_ch    <= grant_ch;
                evt_level <= pend_lvl[grant_ch];
                ptr       <= (grant_ch == CH_LAST) ? '0 : grant_ch + 1'b1;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_antirrebote_scheduler.sv
// Randomised bench for antirrebote_scheduler, checked every cycle against a
// behavioural model of debounce timing, pending events and round-robin delivery.
module tb_antirrebote_scheduler;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int TD   = 4;
    localparam int ST   = 3;
    localparam int NCYC = 4000;

    logic          clk;
    logic          rst;
    logic [N-1:0]  sw_in;
    logic [N-1:0]  sw_db;
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_ch;
    logic          evt_level;
    logic [N-1:0]  evt_ovf;
    logic          ovf_clr;

    int total;
    int bad;
    int delivered;

    bit [N-1:0] m_dl1, m_dl2, m_db, m_wait, m_pend, m_plvl, m_ovf;
    int         m_ticks [N];
    int         m_cyc;
    int         m_ptr;
    bit         m_valid;
    int         m_ch;
    bit         m_lvl;

    antirrebote_scheduler #(
        .N_CH(N), .CH_W(CW), .TICK_DIV(TD), .STABLE_TICKS(ST)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .sw_db(sw_db),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_level(evt_level), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic modelReset();
        m_dl1 = '0; m_dl2 = '0; m_db = '0; m_wait = '0;
        m_pend = '0; m_plvl = '0; m_ovf = '0;
        for (int c = 0; c < N; c++) m_ticks[c] = 0;
        m_cyc = 0; m_ptr = 0; m_valid = 0; m_ch = 0; m_lvl = 0;
    endtask

    // Advances the model by one rising edge using the inputs currently driven.
    task automatic modelStep();
        bit tick, free;
        int g;
        bit [N-1:0] old_pend, old_plvl, cm, cl;
        tick = (m_cyc % TD) == TD - 1;
        free = !m_valid || evt_ready;
        old_pend = m_pend;
        old_plvl = m_plvl;
        cm = '0;
        cl = '0;
        g = -1;
        if (free)
            for (int k = 0; k < N; k++)
                if (g < 0 && old_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        for (int c = 0; c < N; c++) begin
            if (m_dl2[c] == m_db[c]) begin
                m_wait[c] = 0;
            end else if (!m_wait[c]) begin
                m_wait[c] = 1;
                m_ticks[c] = 0;
            end else if (tick) begin
                m_ticks[c]++;
                if (m_ticks[c] == ST) begin
                    cm[c] = 1;
                    cl[c] = m_dl2[c];
                    m_db[c] = m_dl2[c];
                    m_wait[c] = 0;
                end
            end
        end
        if (free) begin
            if (g >= 0) begin
                m_valid = 1;
                m_ch = g;
                m_lvl = old_plvl[g];
                m_ptr = (g + 1) % N;
                m_pend[g] = 0;
            end else begin
                m_valid = 0;
            end
        end
        if (ovf_clr) m_ovf = '0;
        for (int c = 0; c < N; c++) begin
            if (cm[c]) begin
                if (old_pend[c] && g != c) m_ovf[c] = 1;
                m_pend[c] = 1;
                m_plvl[c] = cl[c];
            end
        end
        m_dl2 = m_dl1;
        m_dl1 = sw_in;
        m_cyc++;
    endtask

    task automatic applyStimulus(input logic [N-1:0] sw, input logic rdy, input logic clr);
        sw_in = sw;
        evt_ready = rdy;
        ovf_clr = clr;
        if (m_valid && rdy) delivered++;
        modelStep();
    endtask

    task automatic checkAll();
        checkOutput("sw_db", 32'(sw_db), 32'(m_db));
        checkOutput("evt_valid", 32'(evt_valid), 32'(m_valid));
        checkOutput("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
        if (m_valid) begin
            checkOutput("evt_ch", 32'(evt_ch), 32'(m_ch));
            checkOutput("evt_level", 32'(evt_level), 32'(m_lvl));
        end
    endtask

    task automatic checkResetState(input string when);
        checkOutput({when, "_sw_db"}, 32'(sw_db), 32'd0);
        checkOutput({when, "_evt_valid"}, 32'(evt_valid), 32'd0);
        checkOutput({when, "_evt_ch"}, 32'(evt_ch), 32'd0);
        checkOutput({when, "_evt_level"}, 32'(evt_level), 32'd0);
        checkOutput({when, "_evt_ovf"}, 32'(evt_ovf), 32'd0);
    endtask

    // Asserted in the low phase of the clock so only the asynchronous path can clear state.
    task automatic pulseReset();
        rst = 1'b0;
        #1;
        checkResetState("async_rst");
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] sw_cur;
        logic rdy, clr;
        int den, mode;
        total = 0;
        bad = 0;
        delivered = 0;
        rst = 1'b0;
        sw_in = '0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        modelReset();
        #1;
        checkResetState("por");
        @(negedge clk);
        rst = 1'b1;
        sw_cur = '0;
        applyStimulus(sw_cur, 1'b1, 1'b0);
        for (int cyc = 1; cyc < NCYC; cyc++) begin
            @(negedge clk);
            checkAll();
            if (cyc == 1100 || cyc == 2900) pulseReset();
            mode = (cyc / 250) % 4;
            rdy = 1'b1;
            den = 40;
            case (mode)
                0: begin
                    den = 40;
                    if (cyc % 250 == 0) sw_cur = ~sw_cur;
                end
                1: begin
                    den = (cyc % 250 < 150) ? 3 : 60;
                    rdy = ($urandom_range(3, 0) != 0);
                end
                2: begin
                    den = 25;
                    rdy = ($urandom_range(7, 0) == 0);
                end
                default: begin
                    den = 30;
                    rdy = $urandom_range(1, 0) == 1;
                end
            endcase
            if (cyc >= 1085 && cyc <= 1115) begin
                sw_cur[0] = 1'b1;
            end else begin
                for (int c = 0; c < N; c++)
                    if ($urandom_range(den - 1, 0) == 0) sw_cur[c] = ~sw_cur[c];
            end
            clr = ($urandom_range(49, 0) == 0);
            applyStimulus(sw_cur, rdy, clr);
        end
        @(negedge clk);
        checkAll();
        $display("[TB] events delivered: %0d", delivered);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
